// File: rtl/flash_cache_pkg.sv
// Shared types and default geometry for the flash execute-in-place read cache.
package flash_cache_pkg;

    localparam int unsigned ADDR_W        = 24;
    localparam int unsigned DEFAULT_LINES = 8;
    localparam int unsigned DEFAULT_WORDS = 4;
    localparam int unsigned OFFSET_W      = $clog2(DEFAULT_WORDS);
    localparam int unsigned INDEX_W       = $clog2(DEFAULT_LINES);
    localparam int unsigned TAG_W         = ADDR_W - 2 - OFFSET_W - INDEX_W;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StRefill,
        StRespond,
        StBypass
    } state_e;

endpackage

// File: rtl/flash_cache_mem.sv
// Direct-mapped tag/valid/data store: synchronous read, single write port.
module flash_cache_mem
    import flash_cache_pkg::*;
#(
    parameter int unsigned LINES = DEFAULT_LINES,
    parameter int unsigned WORDS = DEFAULT_WORDS,
    parameter int unsigned TAG_BITS = TAG_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [$clog2(LINES)-1:0] rd_index,
    input  logic [$clog2(WORDS)-1:0] rd_offset,
    output logic                     rd_valid,
    output logic [TAG_BITS-1:0]      rd_tag,
    output logic [31:0]              rd_data,
    input  logic                     we,
    input  logic                     tag_we,
    input  logic [$clog2(LINES)-1:0] wr_index,
    input  logic [$clog2(WORDS)-1:0] wr_offset,
    input  logic [31:0]              wr_data,
    input  logic [TAG_BITS-1:0]      wr_tag,
    input  logic                     wr_valid
);

    logic [31:0]         data_q [LINES*WORDS];
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [LINES-1:0]    valid_q;

    always_ff @(posedge clk) begin
        if (we) begin
            data_q[{wr_index, wr_offset}] <= wr_data;
        end
        if (tag_we) begin
            tag_q[wr_index] <= wr_tag;
        end
        rd_data <= data_q[{rd_index, rd_offset}];
        rd_tag  <= tag_q[rd_index];
    end

    // Flush is applied after the tag write so it wins when both land together.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (tag_we) begin
                valid_q[wr_index] <= wr_valid;
            end
            if (flush) begin
                valid_q <= '0;
            end
            rd_valid <= valid_q[rd_index];
        end
    end

endmodule

// File: rtl/flash_xip_cache.sv
// Direct-mapped read cache between a CPU fetch port and a word-wide flash controller.
module flash_xip_cache
    import flash_cache_pkg::*;
#(
    parameter int unsigned LINES = DEFAULT_LINES,
    parameter int unsigned WORDS = DEFAULT_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cache_en,
    input  logic              cache_flush,
    input  logic              cpu_valid,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_ready,
    output logic [31:0]       cpu_rdata,
    output logic              flash_mem_valid,
    output logic [ADDR_W-1:0] flash_mem_addr,
    input  logic              flash_mem_ready,
    input  logic [31:0]       flash_mem_rdata
);

    localparam int unsigned OFF_BITS = $clog2(WORDS);
    localparam int unsigned IDX_BITS = $clog2(LINES);
    localparam int unsigned TAG_BITS = ADDR_W - 2 - OFF_BITS - IDX_BITS;
    localparam logic [OFF_BITS-1:0] LAST_WORD = OFF_BITS'(WORDS - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-3:0]   waddr_q, waddr_d;
    logic [OFF_BITS-1:0] cnt_q, cnt_d;
    logic                fvalid_q, fvalid_d;
    logic [ADDR_W-1:0]   faddr_q, faddr_d;
    logic                ready_q, ready_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [31:0]         resp_q, resp_d;
    logic                flushed_q, flushed_d;

    logic [OFF_BITS-1:0] req_off;
    logic [IDX_BITS-1:0] req_idx;
    logic [TAG_BITS-1:0] req_tag;
    logic                rd_valid;
    logic [TAG_BITS-1:0] rd_tag;
    logic [31:0]         rd_data;
    logic                mem_we, tag_we, hit;
    logic                unused_addr;

    assign unused_addr = ^cpu_addr[1:0];
    assign req_off = waddr_q[0 +: OFF_BITS];
    assign req_idx = waddr_q[OFF_BITS +: IDX_BITS];
    assign req_tag = waddr_q[OFF_BITS + IDX_BITS +: TAG_BITS];

    // The array is read with the live CPU address so its output is ready in LOOKUP.
    flash_cache_mem #(
        .LINES    (LINES),
        .WORDS    (WORDS),
        .TAG_BITS (TAG_BITS)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .flush     (cache_flush),
        .rd_index  (cpu_addr[2 + OFF_BITS +: IDX_BITS]),
        .rd_offset (cpu_addr[2 +: OFF_BITS]),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .we        (mem_we),
        .tag_we    (tag_we),
        .wr_index  (req_idx),
        .wr_offset (cnt_q),
        .wr_data   (flash_mem_rdata),
        .wr_tag    (req_tag),
        .wr_valid  (!flushed_q)
    );

    // A flush in the lookup cycle invalidates the line being compared.
    assign hit = rd_valid && (rd_tag == req_tag) && !cache_flush;

    always_comb begin
        state_d   = state_q;
        waddr_d   = waddr_q;
        cnt_d     = cnt_q;
        fvalid_d  = fvalid_q;
        faddr_d   = faddr_q;
        ready_d   = 1'b0;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        flushed_d = flushed_q | cache_flush;
        mem_we    = 1'b0;
        tag_we    = 1'b0;
        unique case (state_q)
            StIdle: begin
                fvalid_d = 1'b0;
                if (cpu_valid && !ready_q && !cache_flush) begin
                    waddr_d = cpu_addr[ADDR_W-1:2];
                    if (cache_en) begin
                        state_d = StLookup;
                    end else begin
                        state_d  = StBypass;
                        fvalid_d = 1'b1;
                        faddr_d  = {cpu_addr[ADDR_W-1:2], 2'b00};
                    end
                end
            end
            StLookup: begin
                if (hit) begin
                    ready_d = 1'b1;
                    rdata_d = rd_data;
                    state_d = StIdle;
                end else begin
                    state_d   = StRefill;
                    cnt_d     = '0;
                    flushed_d = 1'b0;
                    fvalid_d  = 1'b1;
                    faddr_d   = {req_tag, req_idx, {OFF_BITS{1'b0}}, 2'b00};
                end
            end
            StRefill: begin
                if (fvalid_q) begin
                    if (flash_mem_ready) begin
                        mem_we   = 1'b1;
                        fvalid_d = 1'b0;
                        if (cnt_q == req_off) begin
                            resp_d = flash_mem_rdata;
                        end
                        if (cnt_q == LAST_WORD) begin
                            tag_we  = 1'b1;
                            state_d = StRespond;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end else begin
                    fvalid_d = 1'b1;
                    faddr_d  = {req_tag, req_idx, cnt_q, 2'b00};
                end
            end
            StRespond: begin
                ready_d = 1'b1;
                rdata_d = resp_q;
                state_d = StIdle;
            end
            StBypass: begin
                if (flash_mem_ready) begin
                    fvalid_d = 1'b0;
                    ready_d  = 1'b1;
                    rdata_d  = flash_mem_rdata;
                    state_d  = StIdle;
                end
            end
            default: begin
                state_d  = StIdle;
                fvalid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            waddr_q   <= '0;
            cnt_q     <= '0;
            fvalid_q  <= 1'b0;
            faddr_q   <= '0;
            ready_q   <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= '0;
            flushed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            waddr_q   <= waddr_d;
            cnt_q     <= cnt_d;
            fvalid_q  <= fvalid_d;
            faddr_q   <= faddr_d;
            ready_q   <= ready_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            flushed_q <= flushed_d;
        end
    end

    assign cpu_ready       = ready_q;
    assign cpu_rdata       = rdata_q;
    assign flash_mem_valid = fvalid_q;
    assign flash_mem_addr  = faddr_q;

endmodule

// File: tb/tb_flash_xip_cache.sv
// Directed bench for flash_xip_cache; flash answers each request with base + word offset.
module tb_flash_xip_cache;

    logic        clk;
    logic        rst;
    logic        cache_en;
    logic        cache_flush;
    logic        cpu_valid;
    logic [23:0] cpu_addr;
    logic        cpu_ready;
    logic [31:0] cpu_rdata;
    logic        flash_mem_valid;
    logic [23:0] flash_mem_addr;
    logic        flash_mem_ready;
    logic [31:0] flash_mem_rdata;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [23:0] fa [8];
    logic [31:0] data;
    int          lat;
    int          n;
    bit          done;

    flash_xip_cache dut (
        .clk             (clk),
        .rst             (rst),
        .cache_en        (cache_en),
        .cache_flush     (cache_flush),
        .cpu_valid       (cpu_valid),
        .cpu_addr        (cpu_addr),
        .cpu_ready       (cpu_ready),
        .cpu_rdata       (cpu_rdata),
        .flash_mem_valid (flash_mem_valid),
        .flash_mem_addr  (flash_mem_addr),
        .flash_mem_ready (flash_mem_ready),
        .flash_mem_rdata (flash_mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One CPU read; acts as a zero-wait flash. Optional flush at issue or at read number flush_on.
    task automatic cpu_read(input logic [23:0] addr, input logic [31:0] base,
                            input bit flush_issue, input int flush_on,
                            output logic [31:0] rdata, output int cycles, output int nreads);
        bit got;
        got    = 1'b0;
        cycles = 0;
        nreads = 0;
        rdata  = '0;
        @(negedge clk);
        cpu_valid   = 1'b1;
        cpu_addr    = addr;
        cache_flush = flush_issue;
        while (!got && cycles < 100) begin
            @(negedge clk);
            cycles++;
            flash_mem_ready = 1'b0;
            cache_flush     = 1'b0;
            if (cpu_ready) begin
                got       = 1'b1;
                rdata     = cpu_rdata;
                cpu_valid = 1'b0;
            end else if (flash_mem_valid) begin
                if (nreads < 8) fa[nreads] = flash_mem_addr;
                nreads++;
                flash_mem_ready = 1'b1;
                flash_mem_rdata = base + 32'(flash_mem_addr[3:2]);
                if (nreads == flush_on) cache_flush = 1'b1;
            end
        end
        check($sformatf("ready_seen_%0h", addr), 32'(got), 32'd1);
        cpu_valid = 1'b0;
        @(negedge clk);
        check($sformatf("ready_single_%0h", addr), 32'(cpu_ready), 32'd0);
    endtask

    initial begin
        rst             = 1'b1;
        cache_en        = 1'b1;
        cache_flush     = 1'b0;
        cpu_valid       = 1'b0;
        cpu_addr        = '0;
        flash_mem_ready = 1'b0;
        flash_mem_rdata = '0;
        repeat (3) @(negedge clk);
        check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
        check("rst_cpu_rdata", cpu_rdata, 32'd0);
        check("rst_flash_valid", 32'(flash_mem_valid), 32'd0);
        check("rst_flash_addr", 32'(flash_mem_addr), 32'd0);
        rst = 1'b0;

        // Cold miss: four ascending flash reads, requested word returned.
        cpu_read(24'h000104, 32'h1000_0000, 1'b0, 0, data, lat, n);
        check("cold_data", data, 32'h1000_0001);
        check("cold_reads", 32'(n), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("cold_addr%0d", i), 32'(fa[i]), 32'h100 + 32'(4 * i));
        end
        check("cold_latency", 32'(lat), 32'd10);

        // Hit in the same line: no flash traffic, two-cycle latency.
        cpu_read(24'h000108, 32'hBAD0_0000, 1'b0, 0, data, lat, n);
        check("hit_data", data, 32'h1000_0002);
        check("hit_reads", 32'(n), 32'd0);
        check("hit_latency", 32'(lat), 32'd2);

        // Conflicting tag evicts the line; the original address then misses.
        cpu_read(24'h000184, 32'h2000_0000, 1'b0, 0, data, lat, n);
        check("evict_data", data, 32'h2000_0001);
        check("evict_reads", 32'(n), 32'd4);
        check("evict_addr0", 32'(fa[0]), 32'h180);
        cpu_read(24'h000104, 32'h1000_0000, 1'b0, 0, data, lat, n);
        check("reread_data", data, 32'h1000_0001);
        check("reread_reads", 32'(n), 32'd4);

        // Flush during the third refill word: data correct, line left invalid.
        cpu_read(24'h00014C, 32'h3000_0000, 1'b0, 3, data, lat, n);
        check("flush_refill_data", data, 32'h3000_0003);
        check("flush_refill_reads", 32'(n), 32'd4);
        cpu_read(24'h00014C, 32'h3000_0000, 1'b0, 0, data, lat, n);
        check("after_flush_reads", 32'(n), 32'd4);
        check("after_flush_data", data, 32'h3000_0003);

        // Flush together with a request in IDLE: deferred one cycle, then misses.
        cpu_read(24'h00014C, 32'h3000_0000, 1'b1, 0, data, lat, n);
        check("idle_flush_reads", 32'(n), 32'd4);
        check("idle_flush_latency", 32'(lat), 32'd11);
        cpu_read(24'h00014C, 32'hBAD0_0000, 1'b0, 0, data, lat, n);
        check("post_fill_hit_reads", 32'(n), 32'd0);
        check("post_fill_hit_data", data, 32'h3000_0003);

        // Bypass: one flash read, data forwarded, nothing allocated.
        cache_en = 1'b0;
        cpu_read(24'h000200, 32'h4000_0000, 1'b0, 0, data, lat, n);
        check("bypass_reads", 32'(n), 32'd1);
        check("bypass_addr", 32'(fa[0]), 32'h200);
        check("bypass_data", data, 32'h4000_0000);
        check("bypass_latency", 32'(lat), 32'd2);
        cache_en = 1'b1;
        cpu_read(24'h000200, 32'h4000_0000, 1'b0, 0, data, lat, n);
        check("after_bypass_reads", 32'(n), 32'd4);
        check("after_bypass_data", data, 32'h4000_0000);

        // Reset in the middle of a refill, followed by a stray flash_mem_ready.
        @(negedge clk);
        cpu_valid = 1'b1;
        cpu_addr  = 24'h0002C8;
        n         = 0;
        done      = 1'b0;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            flash_mem_ready = 1'b0;
            if (flash_mem_valid) begin
                n++;
                if (n == 1) begin
                    flash_mem_ready = 1'b1;
                    flash_mem_rdata = 32'h5000_0000;
                end else begin
                    rst       = 1'b1;
                    cpu_valid = 1'b0;
                    done      = 1'b1;
                end
            end
        end
        check("rst_mid_refill_reached", 32'(done), 32'd1);
        @(negedge clk);
        rst             = 1'b0;
        flash_mem_ready = 1'b1;
        flash_mem_rdata = 32'hDEAD_BEEF;
        check("rst_mid_flash_valid", 32'(flash_mem_valid), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            flash_mem_ready = 1'b0;
            check($sformatf("post_rst_flash_valid%0d", c), 32'(flash_mem_valid), 32'd0);
            check($sformatf("post_rst_cpu_ready%0d", c), 32'(cpu_ready), 32'd0);
        end
        check("post_rst_cpu_rdata", cpu_rdata, 32'd0);
        check("post_rst_flash_addr", 32'(flash_mem_addr), 32'd0);

        // Lines cached before the reset must all miss now.
        cpu_read(24'h000200, 32'h4000_0000, 1'b0, 0, data, lat, n);
        check("post_rst_line0_reads", 32'(n), 32'd4);
        check("post_rst_line0_data", data, 32'h4000_0000);
        cpu_read(24'h00014C, 32'h3000_0000, 1'b0, 0, data, lat, n);
        check("post_rst_line4_reads", 32'(n), 32'd4);
        check("post_rst_line4_data", data, 32'h3000_0003);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
